// File: rtl/rr_arbiter_4to1_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Walks backwards from the farthest offset, so the last hit is the closest one to start.
  function automatic logic [SEL_W-1:0] first_set(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   start);
    logic [SEL_W-1:0] idx;
    first_set = start;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      idx = start + SEL_W'(k - 1);
      if (req[idx]) first_set = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_4to1_if.sv
// Requester/consumer bundle of the 4:1 arbiter; slave is the arbiter side.
interface rr_arbiter_4to1_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [3:0]            req_i;
  logic [DATA_WIDTH-1:0] data0_i;
  logic [DATA_WIDTH-1:0] data1_i;
  logic [DATA_WIDTH-1:0] data2_i;
  logic [DATA_WIDTH-1:0] data3_i;
  logic [3:0]            ack_o;
  logic [1:0]            grant_id_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  req_i, data0_i, data1_i, data2_i, data3_i, ready_i,
    output ack_o, grant_id_o, data_o, valid_o
  );

  modport master (
    output req_i, data0_i, data1_i, data2_i, data3_i, ready_i,
    input  ack_o, grant_id_o, data_o, valid_o
  );
endinterface

// File: rtl/rr_arbiter_4to1_mux.sv
// Word-wide 4:1 multiplexer feeding the arbiter's capture register.
module MUX_4to1 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            i_sel,
  input  logic [DATA_WIDTH-1:0] i_d0,
  input  logic [DATA_WIDTH-1:0] i_d1,
  input  logic [DATA_WIDTH-1:0] i_d2,
  input  logic [DATA_WIDTH-1:0] i_d3,
  output logic [DATA_WIDTH-1:0] o_y
);
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0: o_y = i_d0;
      2'd1: o_y = i_d1;
      2'd2: o_y = i_d2;
      2'd3: o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end
endmodule

// File: rtl/rr_arbiter_4to1.sv
// Round-robin 4:1 arbiter with registered valid/ready output word.
// Define RR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no pointer).
module rr_arbiter_4to1
  import rr_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rr_arbiter_4to1_if.slave       bus
);

  state_t                r_state;
  logic [SEL_W-1:0]      r_grant;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic [NUM_REQ-1:0]    r_ack;
  logic [SEL_W-1:0]      w_start;
  logic [SEL_W-1:0]      w_win;
  logic [DATA_WIDTH-1:0] w_mux;

`ifdef RR_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [SEL_W-1:0] r_ptr;
  assign w_start = r_ptr;
`endif

  assign w_win = first_set(bus.req_i, w_start);

  MUX_4to1 #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .i_sel (w_win),
    .i_d0  (bus.data0_i),
    .i_d1  (bus.data1_i),
    .i_d2  (bus.data2_i),
    .i_d3  (bus.data3_i),
    .o_y   (w_mux)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ack   <= '0;
`ifndef RR_ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|bus.req_i) begin
            r_grant <= w_win;
            r_data  <= w_mux;
            r_valid <= 1'b1;
            r_ack   <= NUM_REQ'(1) << w_win;
`ifndef RR_ARB_FIXED_PRIO_EN
            r_ptr   <= w_win + 1'b1;
`endif
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // valid is always set in BUSY, so ready alone completes the transfer
          if (bus.ready_i) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack_o      = r_ack;
  assign bus.grant_id_o = r_grant;
  assign bus.data_o     = r_data;
  assign bus.valid_o    = r_valid;

endmodule
